// File: rtl/sram64_resp.sv
// 64-bit byte-lane SRAM responder: one request at a time, response after LATENCY cycles.
// Optional macro SRAM64_ACCESS_ERR_EN flags and suppresses out-of-range accesses.
module sram64_resp #(
   parameter int DEPTH_LOG2 = 12,
   parameter int LATENCY    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   output logic        ready,
   input  logic [63:0] addr,
   input  logic [7:0]  wea,
   input  logic [63:0] dina,
   output logic        rvalid,
   output logic [63:0] rdata,
   output logic        resp_err
);

   localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        ready_q;
   logic        rvalid_q;
   logic [63:0] rdata_q;
   logic        err_q;

   logic [63:0] mem_q [DEPTH];

   logic [DEPTH_LOG2-1:0] idx;
   logic                  wr_d;
   logic                  err_d;
   logic                  accept;
   logic [63:0]           rd_word_d;
   logic                  unused_addr_bits;

   assign idx    = addr[DEPTH_LOG2+2:3];
   assign wr_d   = |wea;
   assign accept = ~rst & (state_q == S_IDLE) & req;

`ifdef SRAM64_ACCESS_ERR_EN
   assign err_d = |addr[63:DEPTH_LOG2+3];
`else
   assign err_d = 1'b0;
`endif

   // Lane select comes from wea, and the upper bits matter only when error checking is built in.
   assign unused_addr_bits = ^{addr[63:DEPTH_LOG2+3], addr[2:0]};

   // Response word is captured at the accept edge, so later writes cannot disturb it.
   assign rd_word_d = (wr_d || err_d) ? '0 : mem_q[idx];

   always_ff @(posedge clk) begin
      if (accept && wr_d && !err_d) begin
         for (int unsigned i = 0; i < 8; i++) begin
            if (wea[i]) begin
               mem_q[idx][8*i +: 8] <= dina[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         ready_q  <= 1'b1;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req) begin
                  ready_q <= 1'b0;
                  rdata_q <= rd_word_d;
                  err_q   <= err_d;
                  if (LATENCY == 1) begin
                     state_q  <= S_RESP;
                     rvalid_q <= 1'b1;
                  end else begin
                     state_q <= S_WAIT;
                     cnt_q   <= CNT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == 4'd1) begin
                  state_q  <= S_RESP;
                  rvalid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_RESP: begin
               state_q  <= S_IDLE;
               ready_q  <= 1'b1;
               rvalid_q <= 1'b0;
               rdata_q  <= '0;
               err_q    <= 1'b0;
            end
            default: begin
               state_q  <= S_IDLE;
               ready_q  <= 1'b1;
               rvalid_q <= 1'b0;
               rdata_q  <= '0;
               err_q    <= 1'b0;
            end
         endcase
      end
   end

   assign ready    = ready_q;
   assign rvalid   = rvalid_q;
   assign rdata    = rdata_q;
   assign resp_err = err_q;

endmodule

// File: tb/tb_sram64_resp.sv
// Directed bench for sram64_resp: LATENCY=1 vector table plus LATENCY=3 timing/reset sequences.
module tb_sram64_resp;

`ifdef SRAM64_ACCESS_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        req1 = 1'b0, req3 = 1'b0;
   logic [63:0] addr1 = '0, addr3 = '0;
   logic [7:0]  wea1 = '0, wea3 = '0;
   logic [63:0] dina1 = '0, dina3 = '0;
   logic        ready1, ready3, rvalid1, rvalid3, err1, err3;
   logic [63:0] rdata1, rdata3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sram64_resp #(.DEPTH_LOG2(12), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .req(req1), .ready(ready1), .addr(addr1), .wea(wea1),
      .dina(dina1), .rvalid(rvalid1), .rdata(rdata1), .resp_err(err1)
   );

   sram64_resp #(.DEPTH_LOG2(12), .LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .req(req3), .ready(ready3), .addr(addr3), .wea(wea3),
      .dina(dina3), .rvalid(rvalid3), .rdata(rdata3), .resp_err(err3)
   );

   typedef struct {
      logic [7:0]  wea;
      logic [63:0] addr;
      logic [63:0] dina;
      logic [63:0] exp_d;
      logic        exp_e;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Must be called just after a falling edge; returns at the falling edge inside the response cycle.
   task automatic txn(input int which, input logic [7:0] w, input logic [63:0] a,
                      input logic [63:0] d, input logic [63:0] exp_d, input logic exp_e,
                      input string name);
      int lat;
      int waits;
      lat = (which == 1) ? 1 : 3;
      if (which == 1) begin
         req1 = 1'b1; wea1 = w; addr1 = a; dina1 = d;
      end else begin
         req3 = 1'b1; wea3 = w; addr3 = a; dina3 = d;
      end
      waits = 0;
      while (((which == 1) ? ready1 : ready3) !== 1'b1 && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      if (waits >= 50) begin
         total++;
         bad++;
         $display("FAIL %s_ready_timeout: got ready=0 expected ready=1 within 50 cycles", name);
         req1 = 1'b0;
         req3 = 1'b0;
      end else begin
         @(posedge clk);
         for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (which == 1) begin
               chk({name, "_ready"}, 64'(ready1), 64'd0);
               chk({name, "_rvalid"}, 64'(rvalid1), (k == lat) ? 64'd1 : 64'd0);
               if (k == lat) begin
                  chk({name, "_rdata"}, rdata1, exp_d);
                  chk({name, "_err"}, 64'(err1), 64'(exp_e));
                  req1 = 1'b0;
               end
            end else begin
               chk({name, "_ready"}, 64'(ready3), 64'd0);
               chk({name, "_rvalid"}, 64'(rvalid3), (k == lat) ? 64'd1 : 64'd0);
               if (k == lat) begin
                  chk({name, "_rdata"}, rdata3, exp_d);
                  chk({name, "_err"}, 64'(err3), 64'(exp_e));
                  req3 = 1'b0;
               end
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{8'hFF, 64'h10,   64'h1122334455667788, 64'h0, 1'b0};
      vecs[1]  = '{8'h00, 64'h10,   64'hBAD0BAD0BAD0BAD0, 64'h1122334455667788, 1'b0};
      vecs[2]  = '{8'h0C, 64'h10,   64'h00000000AABB0000, 64'h0, 1'b0};
      vecs[3]  = '{8'h00, 64'h10,   64'h0, 64'h11223344AABB7788, 1'b0};
      vecs[4]  = '{8'hFF, 64'h18,   64'h0, 64'h0, 1'b0};
      vecs[5]  = '{8'h81, 64'h18,   64'hAB333333333333CD, 64'h0, 1'b0};
      vecs[6]  = '{8'h00, 64'h1F,   64'h0, 64'hAB000000000000CD, 1'b0};
      vecs[7]  = '{8'hFF, 64'h7FF8, 64'hDEADBEEFCAFEF00D, 64'h0, 1'b0};
      vecs[8]  = '{8'h00, 64'h7FF8, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0};
      vecs[9]  = '{8'hFF, 64'h0,    64'h0123456789ABCDEF, 64'h0, 1'b0};
      vecs[10] = '{8'hFF, 64'h8000, 64'hFFFFFFFFFFFFFFFF, 64'h0, ERR_EN};
      vecs[11] = '{8'h00, 64'h0,    64'h0,
                   ERR_EN ? 64'h0123456789ABCDEF : 64'hFFFFFFFFFFFFFFFF, 1'b0};
      vecs[12] = '{8'h00, 64'h8000, 64'h0,
                   ERR_EN ? 64'h0 : 64'hFFFFFFFFFFFFFFFF, ERR_EN};
      vecs[13] = '{8'h00, 64'h7FF8, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         chk("idle_ready1", 64'(ready1), 64'd1);
         chk("idle_rvalid1", 64'(rvalid1), 64'd0);
         chk("idle_rdata1", rdata1, 64'd0);
         chk("idle_ready3", 64'(ready3), 64'd1);
         chk("idle_rvalid3", 64'(rvalid3), 64'd0);
         @(negedge clk);
      end

      for (int i = 0; i < 14; i++) begin
         txn(1, vecs[i].wea, vecs[i].addr, vecs[i].dina, vecs[i].exp_d, vecs[i].exp_e,
             $sformatf("vec%0d", i));
      end
      @(negedge clk);
      chk("l1_after_ready", 64'(ready1), 64'd1);
      chk("l1_after_rvalid", 64'(rvalid1), 64'd0);

      // LATENCY=3: write, then back-to-back reads with req held high throughout.
      txn(3, 8'hFF, 64'h10, 64'h0F0E0D0C0B0A0908, 64'h0, 1'b0, "l3_wr");
      @(negedge clk);
      chk("l3_ready_after_resp", 64'(ready3), 64'd1);
      chk("l3_rvalid_after_resp", 64'(rvalid3), 64'd0);
      txn(3, 8'h00, 64'h10, 64'h0, 64'h0F0E0D0C0B0A0908, 1'b0, "l3_rd_a");
      txn(3, 8'h04, 64'h10, 64'h0000000000770000, 64'h0, 1'b0, "l3_wr_b");
      txn(3, 8'h00, 64'h10, 64'h0, 64'h0F0E0D0C0B770908, 1'b0, "l3_rd_c");

      // Reset one cycle after accepting a write: no response, write stays committed.
      txn(3, 8'hFF, 64'h0, 64'h1111111111111111, 64'h0, 1'b0, "l3_init0");
      @(negedge clk);
      req3 = 1'b1; wea3 = 8'h01; addr3 = 64'h0; dina3 = 64'h5A;
      @(posedge clk);
      @(negedge clk);
      req3 = 1'b0;
      rst  = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk("rst_mid_rvalid", 64'(rvalid3), 64'd0);
         chk("rst_mid_ready", 64'(ready3), 64'd1);
         @(negedge clk);
      end
      txn(3, 8'h00, 64'h0, 64'h0, 64'h111111111111115A, 1'b0, "rst_mid_rd");

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram64_resp.md
Name: sram64_resp

Overview:
- Memory-side responder for the 64-bit byte-lane SRAM request stream produced by the core's load/store translation.
- Holds a 2^DEPTH_LOG2 x 64-bit word array with per-byte write enables.
- Accepts one request at a time through a req/ready handshake. Returns a response (read data or write acknowledge) after a programmable number of wait cycles.
- Used as the data-memory model behind the pipeline and as a simple on-chip scratchpad.

Parameters:
- DEPTH_LOG2, 12, log2 of word count; array holds 2^DEPTH_LOG2 64-bit words.
- LATENCY, 1, cycles from accept edge to rvalid; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  1  request valid.
- ready  output  1  responder can accept; a transfer occurs on the edge where req && ready.
- addr  input  64  byte address; word index = addr[DEPTH_LOG2+2:3]; addr[2:0] ignored (lanes are selected by wea).
- wea  input  8  byte write enables; bit i writes byte lane i (bits 8i+7:8i). 0 = read request.
- dina  input  64  write data, already lane-aligned by the initiator.
- rvalid  output  1  one-cycle response pulse.
- rdata  output  64  response data; valid only while rvalid=1.
- resp_err  output  1  access error flag; valid only while rvalid=1.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, ready=1, rvalid=0, rdata=0, resp_err=0, latency counter=0.
  - Array contents are not cleared.
  - Reset during WAIT or RESP aborts the pending response; no rvalid follows.
  - A write already committed at its accept edge stays committed.
- States:
  - IDLE: ready=1, rvalid=0. On req=1, accept:
    - latch wea, the error flag, and the read word;
    - commit the write;
    - if LATENCY==1 go to RESP, else go to WAIT with counter=LATENCY-1.
    - req=0 stays in IDLE.
  - WAIT: ready=0. Counter decrements each edge; when counter reaches 1 on an edge, next state is RESP.
  - RESP: ready=0, rvalid=1 for exactly one cycle, then IDLE.
- Latency and throughput:
  - Request accepted at edge E; rvalid is high in the cycle after edge E+LATENCY-1, i.e. LATENCY cycles after acceptance.
  - Throughput is one transfer per LATENCY+1 cycles.
- Writes (wea != 0):
  - At the accept edge, each lane with wea[i]=1 takes dina[8i+7:8i]; other lanes keep their old value.
  - Response has rdata=0.
- Reads (wea == 0):
  - rdata = full stored word at the accept edge; later writes cannot disturb a pending response.
  - Any wea value, including non-contiguous patterns, is honoured lane by lane; no sign or zero extension is done here (the initiator performs it).
- Handshake:
  - req is ignored while ready=0; no queuing.
  - The initiator holds req/addr/wea/dina stable until accepted.
  - Inputs are sampled only at the accept edge.
- Addressing: word index is taken modulo depth (upper address bits dropped), unless the optional feature is enabled.

Optional Feature:
- Macro: SRAM64_ACCESS_ERR_EN.
- Defined:
  - an access is in error if addr[63:DEPTH_LOG2+3] != 0;
  - an erroring write does not modify the array;
  - an erroring read returns rdata=0;
  - the response carries resp_err=1;
  - latency and handshake are unchanged.
- Undefined: resp_err is tied to 0 and out-of-range addresses alias modulo depth.

Test Plan:
- Reset, then idle: ready=1, rvalid=0, rdata=0 from the first cycle after reset, with req=0 for 10 cycles.
- Full write then read, LATENCY=1:
  - write addr=0x10, wea=0xFF, dina=0x1122334455667788 -> rvalid 1 cycle later with rdata=0;
  - read addr=0x10 -> rdata=0x1122334455667788.
- Byte-lane merge:
  - over the word from the previous scenario, write addr=0x10, wea=0x0C, dina=0x00000000AABB0000;
  - read addr=0x10 -> rdata=0x11223344AABB7788.
- LATENCY=3 timing:
  - read accepted at cycle 5 -> ready=0 in cycles 6-8, rvalid=1 only in cycle 8, ready=1 in cycle 9;
  - a req held high in cycles 6-8 is not accepted until cycle 9.
- Reset mid-operation, LATENCY=3: rst=1 one cycle after accepting a write (wea=0x01, dina=0x5A, addr=0x0) -> no rvalid; a later read of 0x0 returns low byte 0x5A.
- With SRAM64_ACCESS_ERR_EN, DEPTH_LOG2=12:
  - write to addr=0x8000 -> resp_err=1;
  - a read of addr=0x0 shows no aliasing: word unchanged.
  - Without the macro, the same write aliases onto word 0 and resp_err=0.
